// File: rtl/bram_access_arbiter_pkg.sv
// bram_access_arbiter_pkg: the arbiter FSM state type and the constants that map
// a word index onto the BRAM byte address.
package bram_access_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ      = 2'd2,
      ST_READ_WAIT = 2'd3
   } state_t;

   localparam logic       BRAM_BASE_BIT = 1'b1;
   localparam int         BYTE_OFS_W    = 5;
   localparam int         BRAM_ADDR_W   = 16;
   localparam int         WORD_IDX_W    = BRAM_ADDR_W - 1 - BYTE_OFS_W;
   localparam logic [3:0] WEA_ALL       = 4'b1111;

   // The BRAM window sits in the upper half of the byte space, one word per 32 bytes.
   function automatic logic [BRAM_ADDR_W-1:0] word_to_byte_addr(input logic [WORD_IDX_W-1:0] idx);
      return {BRAM_BASE_BIT, idx, {BYTE_OFS_W{1'b0}}};
   endfunction

endpackage

// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: shares one BRAM port between a record-path writer and a playback-path reader.
// Define ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests; default build is write-first.
module bram_access_arbiter
   import bram_access_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WR_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              bram_en,
   output logic [3:0]        bram_wea,
   output logic [15:0]       bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              wr_late,
   input  logic              clr_err
);

   localparam int              CNT_W    = $clog2(WR_TIMEOUT + 2);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WR_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WR_TIMEOUT);

   state_t            r_state;
   logic              r_wr_gnt;
   logic              r_rd_gnt;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_bram_en;
   logic [3:0]        r_bram_wea;
   logic [15:0]       r_bram_addr;
   logic [DATA_W-1:0] r_bram_din;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_wr_late;

   logic              w_pick_wr;
   logic              w_waiting;
   logic [CNT_W-1:0]  w_cnt_nxt;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_prio_wr;

   assign w_pick_wr = wr_req && (!rd_req || r_prio_wr);

   // The side just served loses the next tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prio_wr <= 1'b1;
      end else if (r_state == ST_IDLE) begin
         if (w_pick_wr)   r_prio_wr <= 1'b0;
         else if (rd_req) r_prio_wr <= 1'b1;
      end
   end
`else
   assign w_pick_wr = wr_req;
`endif

   // Outputs are registered on the transition into each state, so every BRAM
   // control is a clean Moore output of the state it belongs to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_wr_gnt    <= 1'b0;
         r_rd_gnt    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_bram_en   <= 1'b0;
         r_bram_wea  <= '0;
         r_bram_addr <= word_to_byte_addr('0);
         r_bram_din  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; the pulse defaults below are
         // overridden later in the same block, and the last assignment wins.
         r_wr_gnt   <= 1'b0;
         r_rd_gnt   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_bram_en  <= 1'b0;
         r_bram_wea <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_wr) begin
                  r_state     <= ST_WRITE;
                  r_wr_gnt    <= 1'b1;
                  r_bram_en   <= 1'b1;
                  r_bram_wea  <= WEA_ALL;
                  r_bram_addr <= word_to_byte_addr(WORD_IDX_W'(wr_addr));
                  r_bram_din  <= wr_data;
               end else if (rd_req) begin
                  r_state     <= ST_READ;
                  r_rd_gnt    <= 1'b1;
                  r_bram_en   <= 1'b1;
                  r_bram_addr <= word_to_byte_addr(WORD_IDX_W'(rd_addr));
               end
            end
            ST_WRITE:     r_state <= ST_IDLE;
            ST_READ:      r_state <= ST_READ_WAIT;
            ST_READ_WAIT: begin
               r_rd_data  <= bram_dout;
               r_rd_valid <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default:      r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_waiting = wr_req && !r_wr_gnt;
   assign w_cnt_nxt = !w_waiting            ? '0 :
                      (r_wait_cnt == CNT_SAT) ? CNT_SAT : r_wait_cnt + CNT_W'(1);

   // A late flag raised in the same cycle as clr_err must survive it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
         r_wr_late  <= 1'b0;
      end else begin
         r_wait_cnt <= w_cnt_nxt;
         if (w_cnt_nxt > CNT_LIM) r_wr_late <= 1'b1;
         else if (clr_err)        r_wr_late <= 1'b0;
      end
   end

   assign wr_gnt    = r_wr_gnt;
   assign rd_gnt    = r_rd_gnt;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign bram_en   = r_bram_en;
   assign bram_wea  = r_bram_wea;
   assign bram_addr = r_bram_addr;
   assign bram_din  = r_bram_din;
   assign wr_late   = r_wr_late;

endmodule

// File: doc/bram_access_arbiter.md
BRAM_ACCESS_ARBITER -- requirements
Module: bram_access_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-index width of both requester address ports.
REQ-002 Parameter DATA_W, default 32, BRAM word width.
REQ-003 Parameter WR_TIMEOUT, default 8, maximum cycles a pending write may wait before being flagged late.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 wr_req  in  1  record-path write request, held high until wr_gnt.
REQ-007 wr_addr  in  ADDR_W  write word index.
REQ-008 wr_data  in  DATA_W  write word.
REQ-009 wr_gnt  out  1  one-cycle pulse: write performed this cycle.
REQ-010 rd_req  in  1  playback-path read request, held high until rd_gnt.
REQ-011 rd_addr  in  ADDR_W  read word index.
REQ-012 rd_gnt  out  1  one-cycle pulse: read issued this cycle.
REQ-013 rd_data  out  DATA_W  registered read word.
REQ-014 rd_valid  out  1  one-cycle pulse: rd_data holds the new word.
REQ-015 bram_en  out  1  BRAM enable.
REQ-016 bram_wea  out  4  BRAM byte write enables.
REQ-017 bram_addr  out  16  BRAM byte address = {1'b1, word index, 5'b00000}.
REQ-018 bram_din  out  DATA_W  BRAM write data.
REQ-019 bram_dout  in  DATA_W  BRAM read data, valid one cycle after read issue.
REQ-020 wr_late  out  1  sticky: some write waited more than WR_TIMEOUT cycles.
REQ-021 clr_err  in  1  synchronous clear of wr_late.

Function
REQ-022 FSM states: IDLE, WRITE, READ, READ_WAIT; Moore-decoded BRAM outputs.
REQ-023 IDLE: bram_en=0, bram_wea=0000; wr_req -> WRITE, rd_req -> READ, neither -> IDLE.
REQ-024 WRITE (one cycle): bram_en=1, bram_wea=1111, bram_addr from wr_addr, bram_din=wr_data, wr_gnt=1; next IDLE.
REQ-025 READ (one cycle): bram_en=1, bram_wea=0000, bram_addr from rd_addr, rd_gnt=1; next READ_WAIT.
REQ-026 READ_WAIT: rd_data<=bram_dout at cycle end; rd_valid=1 the following cycle; next IDLE.
REQ-027 Latency: request seen in IDLE at edge N -> grant cycle N+1; read data valid (rd_valid) at N+3.
REQ-028 Simultaneous wr_req and rd_req in IDLE resolved per REQ-036/REQ-037.
REQ-029 Requests arriving in WRITE/READ/READ_WAIT wait; never dropped, never double-granted.
REQ-030 Request deasserted before grant is abandoned; no BRAM access occurs.
REQ-031 Wait counter (width ceil(log2(WR_TIMEOUT+2))) counts cycles wr_req=1 without wr_gnt, saturates, clears on wr_gnt or wr_req=0.
REQ-032 Counter exceeding WR_TIMEOUT sets wr_late; clr_err clears it; set wins over simultaneous clr_err.
REQ-033 bram_addr bit 15 always 1, bits 4:0 always 0; index wrap is the requester's responsibility.

Reset
REQ-034 reset=0 forces IDLE immediately: wr_gnt, rd_gnt, rd_valid, bram_en, wr_late = 0; bram_wea=0000; rd_data=0; wait counter=0; priority pointer=write.
REQ-035 Reset during READ/READ_WAIT: no rd_valid is produced for that read after release.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served last (pointer updates on each grant; initial favour write).
REQ-037 Without ARB_ROUND_ROBIN_EN: fixed priority, write always wins over read.

Structure
REQ-038 Shared package holds state enumeration, BRAM base-bit constant (1'b1), byte-offset width (5), and WEA_ALL=4'b1111.
REQ-039 No sub-module required; FSM, wait counter and priority pointer reside in one module.

Verification
REQ-040 wr_req=1, wr_addr=3, wr_data=32'hDEADBEEF -> next cycle wr_gnt=1, bram_wea=1111, bram_addr=16'h8060, bram_din=DEADBEEF.
REQ-041 rd_req=1, rd_addr=3, bram_dout=32'h12345678 -> rd_gnt next cycle, rd_valid two cycles later with rd_data=12345678.
REQ-042 wr_req and rd_req asserted together, held: fixed mode -> write then read; round-robin with last grant write -> read first.
REQ-043 rd_req held during 3 back-to-back reads, wr_req raised: write waits at most one transaction; wr_late stays 0 at WR_TIMEOUT=8.
REQ-044 wr_req held 10 cycles with FSM forced busy -> wr_late=1; clr_err pulse -> 0.
REQ-045 reset=0 asserted in READ_WAIT -> all outputs 0 at once; no rd_valid after release.
